// File: rtl/jk_cmd_sequencer_if.sv
// Command handshake bundle for jk_cmd_sequencer: {op,cnt} offered on cmd_vld, taken on cmd_rdy.
// The producer side is the master; the sequencer is the slave.
interface jk_cmd_sequencer_if #(
   parameter int CNT_W = 4
);
   logic             cmd_vld;
   logic             cmd_rdy;
   logic [1:0]       cmd_op;
   logic [CNT_W-1:0] cmd_cnt;

   modport master (output cmd_vld, output cmd_op, output cmd_cnt, input cmd_rdy);
   modport slave  (input cmd_vld, input cmd_op, input cmd_cnt, output cmd_rdy);
endinterface

// File: rtl/jk_cmd_sequencer.sv
// jk_cmd_sequencer: 2-entry {op,cnt} queue replayed on registered J/K; J/K from the edge after accept,
// cmd_rdy = !full (no push when full). Optional Q_IN/MISMATCH checker under `JKSEQ_QCHECK_EN.
module jk_cmd_sequencer #(
   parameter int CNT_W = 4
) (
   input  logic              clk_i,
   input  logic              rst_i,
   jk_cmd_sequencer_if.slave cmd_if,
   output logic              j_o,
   output logic              k_o,
   output logic              busy_o,
   output logic              done_o,
`ifdef JKSEQ_QCHECK_EN
   input  logic              q_in_i,
   output logic              mismatch_o,
`endif
   output logic              q_pred_o
);

   typedef struct packed {
      logic [1:0]       op;
      logic [CNT_W-1:0] cnt;
   } cmd_t;

   typedef enum logic {S_IDLE, S_RUN} state_t;

   cmd_t             mem_q [2];
   logic             wr_ptr_q, wr_ptr_d;
   logic             rd_ptr_q, rd_ptr_d;
   logic [1:0]       fill_q, fill_d;
   state_t           state_q, state_d;
   logic [CNT_W-1:0] ctr_q, ctr_d;
   logic             j_q, j_d, k_q, k_d;
   logic             done_q, done_d;
   logic             q_pred_q, q_pred_d;
   logic             push, pop, empty, full;
   cmd_t             head;

   assign empty          = (fill_q == 2'd0);
   assign full           = (fill_q == 2'd2);
   assign head           = mem_q[rd_ptr_q];
   assign push           = cmd_if.cmd_vld && !full;
   assign cmd_if.cmd_rdy = !full;

   always_comb begin
      wr_ptr_d = wr_ptr_q ^ push;
      rd_ptr_d = rd_ptr_q ^ pop;
      fill_d   = fill_q;
      if (push && !pop) begin
         fill_d = fill_q + 2'd1;
      end else if (!push && pop) begin
         fill_d = fill_q - 2'd1;
      end
   end

   // ctr holds the remaining drive cycles minus one, so the final cycle is ctr==0.
   always_comb begin
      state_d = state_q;
      ctr_d   = ctr_q;
      j_d     = j_q;
      k_d     = k_q;
      done_d  = 1'b0;
      pop     = 1'b0;
      case (state_q)
         S_IDLE: begin
            j_d = 1'b0;
            k_d = 1'b0;
            if (!empty) begin
               pop = 1'b1;
               if (head.cnt != '0) begin
                  {j_d, k_d} = head.op;
                  ctr_d      = head.cnt - 1'b1;
                  state_d    = S_RUN;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         default: begin
            ctr_d = ctr_q - 1'b1;
            if (ctr_q == '0) begin
               done_d = 1'b1;
               // A zero-count head is left for IDLE so it gets its own DONE pulse.
               if (!empty && head.cnt != '0) begin
                  pop        = 1'b1;
                  {j_d, k_d} = head.op;
                  ctr_d      = head.cnt - 1'b1;
               end else begin
                  j_d     = 1'b0;
                  k_d     = 1'b0;
                  ctr_d   = '0;
                  state_d = S_IDLE;
               end
            end
         end
      endcase
   end

   always_comb begin
      case ({j_q, k_q})
         2'b00:   q_pred_d = q_pred_q;
         2'b01:   q_pred_d = 1'b0;
         2'b10:   q_pred_d = 1'b1;
         default: q_pred_d = ~q_pred_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (push) begin
         mem_q[wr_ptr_q].op  <= cmd_if.cmd_op;
         mem_q[wr_ptr_q].cnt <= cmd_if.cmd_cnt;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         fill_q   <= 2'd0;
         state_q  <= S_IDLE;
         ctr_q    <= '0;
         j_q      <= 1'b0;
         k_q      <= 1'b0;
         done_q   <= 1'b0;
         q_pred_q <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         fill_q   <= fill_d;
         state_q  <= state_d;
         ctr_q    <= ctr_d;
         j_q      <= j_d;
         k_q      <= k_d;
         done_q   <= done_d;
         q_pred_q <= q_pred_d;
      end
   end

`ifdef JKSEQ_QCHECK_EN
   logic mismatch_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         mismatch_q <= 1'b0;
      end else if (q_in_i != q_pred_q) begin
         mismatch_q <= 1'b1;
      end
   end

   assign mismatch_o = mismatch_q;
`endif

   assign j_o      = j_q;
   assign k_o      = k_q;
   assign busy_o   = (state_q == S_RUN);
   assign done_o   = done_q;
   assign q_pred_o = q_pred_q;

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// Directed bench for jk_cmd_sequencer: a scoreboard of accepted {op,cnt} checked against observed
// J/K runs at each DONE, a JK model checking q_pred every cycle, plus directed timing checks.
module tb_jk_cmd_sequencer;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic j, k, busy, done, q_pred;
   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;

   typedef struct {
      logic [1:0] op;
      int         cnt;
   } exp_t;

   exp_t sb[$];

   logic [1:0] b_jk   [7] = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b01, 2'b01, 2'b00};
   logic       b_done [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
   logic       b_q    [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
   logic       b_busy [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

   jk_cmd_sequencer_if #(.CNT_W(4)) cmd_if ();

`ifdef JKSEQ_QCHECK_EN
   logic q_in;
   logic mismatch;
   logic tie0 = 1'b0;
   logic ff_q = 1'b0;

   assign q_in = tie0 ? 1'b0 : ff_q;

   always @(posedge clk) begin
      if (rst) ff_q <= 1'b0;
      else begin
         case ({j, k})
            2'b01:   ff_q <= 1'b0;
            2'b10:   ff_q <= 1'b1;
            2'b11:   ff_q <= ~ff_q;
            default: ff_q <= ff_q;
         endcase
      end
   end
`endif

   jk_cmd_sequencer #(.CNT_W(4)) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .cmd_if     (cmd_if),
      .j_o        (j),
      .k_o        (k),
      .busy_o     (busy),
      .done_o     (done),
`ifdef JKSEQ_QCHECK_EN
      .q_in_i     (q_in),
      .mismatch_o (mismatch),
`endif
      .q_pred_o   (q_pred)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drives one command from the negedge and returns just after the accepting edge.
   task automatic send(input logic [1:0] op, input logic [3:0] cnt, output int acc_cyc);
      int   n;
      logic ok;
      exp_t e;
      n = 0;
      @(negedge clk);
      cmd_if.cmd_vld = 1'b1;
      cmd_if.cmd_op  = op;
      cmd_if.cmd_cnt = cnt;
      while (!cmd_if.cmd_rdy && n < 100) begin
         @(negedge clk);
         n++;
      end
      ok = cmd_if.cmd_rdy;
      chk("send_accept", 32'(ok), 32'd1);
      @(posedge clk);
      #1;
      acc_cyc = cyc;
      if (ok) begin
         e.op  = (cnt == 4'd0) ? 2'b00 : op;
         e.cnt = int'(cnt);
         sb.push_back(e);
      end
   endtask

   task automatic drain(input string tag);
      int n;
      n = 0;
      while (sb.size() != 0 && n < 200) begin
         @(negedge clk);
         #2;
         n++;
      end
      chk(tag, 32'(sb.size()), 32'd0);
   endtask

   // Monitor: JK flip-flop model for q_pred, and run capture compared to the scoreboard on DONE.
   logic       rst_prev = 1'b1;
   logic       j_prev = 1'b0;
   logic       k_prev = 1'b0;
   logic       q_model = 1'b0;
   logic [1:0] run_op = 2'b00;
   int         run_len = 0;

   always begin
      exp_t e;
      @(negedge clk);
      #1;
      if (rst_prev) begin
         q_model = 1'b0;
         run_len = 0;
         run_op  = 2'b00;
         chk("mon_rst_done", 32'(done), 32'd0);
      end else begin
         case ({j_prev, k_prev})
            2'b01:   q_model = 1'b0;
            2'b10:   q_model = 1'b1;
            2'b11:   q_model = ~q_model;
            default: q_model = q_model;
         endcase
         if (done) begin
            if (sb.size() == 0) begin
               chk("mon_unexpected_done", 32'(done), 32'd0);
            end else begin
               e = sb.pop_front();
               chk("sb_op", 32'(run_op), 32'(e.op));
               chk("sb_len", 32'(run_len), 32'(e.cnt));
            end
            run_len = 0;
            run_op  = 2'b00;
         end
         if (busy) begin
            if (run_len > 0) chk("mon_jk_stable", 32'({j, k}), 32'(run_op));
            run_op = {j, k};
            run_len++;
         end else begin
            chk("mon_idle_jk", 32'({j, k}), 32'd0);
         end
      end
      chk("mon_q_pred", 32'(q_pred), 32'(q_model));
      rst_prev = rst;
      j_prev   = j;
      k_prev   = k;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: time limit reached, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

   initial begin
      int t0, t3, acc;
      cmd_if.cmd_vld = 1'b0;
      cmd_if.cmd_op  = 2'b00;
      cmd_if.cmd_cnt = 4'd0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_jk", 32'({j, k}), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_rdy", 32'(cmd_if.cmd_rdy), 32'd1);
      chk("rst_q", 32'(q_pred), 32'd0);
      rst = 1'b0;

      // {10,3} into an idle empty queue
      send(2'b10, 4'd3, acc);
      @(negedge clk);
      cmd_if.cmd_vld = 1'b0;
      chk("a_not_started", 32'(busy), 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("a_jk", 32'({j, k}), 32'd2);
         chk("a_busy", 32'(busy), 32'd1);
      end
      @(negedge clk);
      chk("a_end_jk", 32'({j, k}), 32'd0);
      chk("a_done", 32'(done), 32'd1);
      chk("a_busy_end", 32'(busy), 32'd0);
      chk("a_q", 32'(q_pred), 32'd1);
      @(negedge clk);
      chk("a_done_pulse", 32'(done), 32'd0);
      drain("a_drain");

      // {10,0}: DONE only, Q unchanged at 1
      send(2'b10, 4'd0, acc);
      @(negedge clk);
      cmd_if.cmd_vld = 1'b0;
      chk("e_busy0", 32'(busy), 32'd0);
      @(negedge clk);
      chk("e_done", 32'(done), 32'd1);
      chk("e_busy1", 32'(busy), 32'd0);
      chk("e_jk", 32'({j, k}), 32'd0);
      chk("e_q", 32'(q_pred), 32'd1);
      @(negedge clk);
      chk("e_done_pulse", 32'(done), 32'd0);
      chk("e_q_hold", 32'(q_pred), 32'd1);
      drain("e_drain");

      // Reset mid-RUN with a second command queued
      send(2'b11, 4'd7, acc);
      send(2'b10, 4'd5, acc);
      @(negedge clk);
      cmd_if.cmd_vld = 1'b0;
      chk("c_busy_pre", 32'(busy), 32'd1);
      rst = 1'b1;
      sb.delete();
      @(negedge clk);
      chk("c_jk", 32'({j, k}), 32'd0);
      chk("c_busy", 32'(busy), 32'd0);
      chk("c_rdy", 32'(cmd_if.cmd_rdy), 32'd1);
      chk("c_q", 32'(q_pred), 32'd0);
      chk("c_done", 32'(done), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (4) begin
         @(negedge clk);
         chk("c_flushed_busy", 32'(busy), 32'd0);
         chk("c_flushed_jk", 32'({j, k}), 32'd0);
      end

      // {11,4} then {01,2} back-to-back
      send(2'b11, 4'd4, acc);
      send(2'b01, 4'd2, acc);
      @(negedge clk);
      cmd_if.cmd_vld = 1'b0;
      for (int c = 0; c < 7; c++) begin
         if (c > 0) @(negedge clk);
         chk("b_jk", 32'({j, k}), 32'(b_jk[c]));
         chk("b_done", 32'(done), 32'(b_done[c]));
         chk("b_q", 32'(q_pred), 32'(b_q[c]));
         chk("b_busy", 32'(busy), 32'(b_busy[c]));
      end
      drain("b_drain");

      // Backpressure: two accepted behind a {00,15}, third waits for the first pop
      send(2'b00, 4'd15, t0);
      send(2'b10, 4'd1, acc);
      send(2'b11, 4'd2, acc);
      @(negedge clk);
      chk("d_full_rdy", 32'(cmd_if.cmd_rdy), 32'd0);
      send(2'b01, 4'd3, t3);
      chk("d_third_accept", 32'(t3 - t0), 32'd17);
      @(negedge clk);
      cmd_if.cmd_vld = 1'b0;
      drain("d_drain");

`ifdef JKSEQ_QCHECK_EN
      chk("qc_clean", 32'(mismatch), 32'd0);
      @(negedge clk);
      tie0 = 1'b1;
      send(2'b10, 4'd1, acc);
      @(negedge clk);
      cmd_if.cmd_vld = 1'b0;
      @(negedge clk);
      chk("qc_before_q", 32'(mismatch), 32'd0);
      @(negedge clk);
      chk("qc_q_set", 32'(q_pred), 32'd1);
      chk("qc_not_yet", 32'(mismatch), 32'd0);
      @(negedge clk);
      chk("qc_flag", 32'(mismatch), 32'd1);
      repeat (3) @(negedge clk);
      chk("qc_sticky", 32'(mismatch), 32'd1);
      drain("qc_drain");
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("qc_rst_clear", 32'(mismatch), 32'd0);
`endif

      repeat (2) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
